// File: rtl/cam_sram_capture.sv
// rtl/cam_sram_capture.sv - packs camera pixels into SRAM words per frame, then hands the SRAM to the JPEG encoder
// Optional feature: define CAM_SRAM_TEST_PATTERN_EN to replace every pixel with a per-word counter.
module cam_sram_capture #(
    parameter int DW    = 32,
    parameter int PIX_W = 8,
    parameter int AW    = 18,
    parameter int ROWS  = 384
) (
    input  logic             clk_100,
    input  logic             rst,
    input  logic             cam_pclk,
    input  logic             cam_href,
    input  logic             cam_vsyn,
    input  logic [PIX_W-1:0] cam_data,
    input  logic             configure_over,
    input  logic             jpeg_done,
    input  logic [AW-1:0]    address_from_dwt,
    inout  wire  [DW-1:0]    data_sram,
    output logic [AW-1:0]    address_to_sram,
    output logic             write_en_n,
    output logic             chip_en,
    output logic             output_en,
    output logic             adv,
    output logic [DW/8-1:0]  byte_en,
    output logic             jpeg_start_from_sram,
    output logic             jpeg_working,
    output logic [DW-1:0]    data_to_jpeg,
    output logic             overflow
);

    localparam int PPW = DW / PIX_W;
    localparam int LW  = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int RW  = $clog2(ROWS + 1);
    localparam logic [LW-1:0] LAST_LANE = LW'(PPW - 1);
    localparam logic [RW-1:0] ROW_LIMIT = RW'(ROWS);

    typedef enum logic [2:0] {
        IDLE, WAIT_WORD, WR1, WR2, JPEG_START, JPEG_BUSY
    } state_t;

    state_t         state_q;
    logic           pclk_s1_q, pclk_s2_q, href_s1_q, href_s2_q, vs_s1_q, vs_s2_q;
    logic [LW-1:0]  lane_q, lane_d;
    logic [RW-1:0]  row_q;
    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  assemble_q, word_d, wr_q;
    logic           we_n_q, start_q, working_q, overflow_q;
    logic [PIX_W-1:0] pixel;
    logic           pclk_rise, vs_rise, href_fall, capturing, sample, word_ready;
    logic           row_full, frame_start;

`ifdef CAM_SRAM_TEST_PATTERN_EN
    logic [PIX_W-1:0] pattern_q;
    assign pixel = pattern_q;
`else
    assign pixel = cam_data;
`endif

    assign pclk_rise   = pclk_s1_q & ~pclk_s2_q;
    assign vs_rise     = vs_s1_q & ~vs_s2_q;
    assign href_fall   = ~href_s1_q & href_s2_q;
    assign capturing   = (state_q == WAIT_WORD) || (state_q == WR1) || (state_q == WR2);
    assign sample      = capturing && pclk_rise && href_s2_q;
    assign word_ready  = sample && (lane_q == LAST_LANE);
    assign row_full    = (row_q == ROW_LIMIT);
    assign frame_start = vs_rise && (((state_q == IDLE) && configure_over) || capturing);
    assign lane_d      = (lane_q == LAST_LANE) ? '0 : lane_q + 1'b1;

    // Lane 0 lands in the most significant pixel slot of the word.
    always_comb begin
        word_d = assemble_q;
        for (int l = 0; l < PPW; l++) begin
            if (lane_q == LW'(l)) begin
                word_d[DW-1-l*PIX_W -: PIX_W] = pixel;
            end
        end
    end

    always_ff @(posedge clk_100 or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pclk_s1_q  <= 1'b0;
            pclk_s2_q  <= 1'b0;
            href_s1_q  <= 1'b0;
            href_s2_q  <= 1'b0;
            vs_s1_q    <= 1'b0;
            vs_s2_q    <= 1'b0;
            lane_q     <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            assemble_q <= '0;
            wr_q       <= '0;
            we_n_q     <= 1'b1;
            start_q    <= 1'b0;
            working_q  <= 1'b0;
            overflow_q <= 1'b0;
`ifdef CAM_SRAM_TEST_PATTERN_EN
            pattern_q  <= '0;
`endif
        end else begin
            pclk_s1_q <= cam_pclk;
            pclk_s2_q <= pclk_s1_q;
            href_s1_q <= cam_href;
            href_s2_q <= href_s1_q;
            vs_s1_q   <= cam_vsyn;
            vs_s2_q   <= vs_s1_q;
            start_q   <= 1'b0;
            if (frame_start) begin
                state_q    <= WAIT_WORD;
                we_n_q     <= 1'b1;
                addr_q     <= '0;
                row_q      <= '0;
                lane_q     <= '0;
                overflow_q <= 1'b0;
`ifdef CAM_SRAM_TEST_PATTERN_EN
                pattern_q  <= '0;
`endif
            end else begin
                if (sample) begin
                    lane_q     <= lane_d;
                    assemble_q <= word_d;
                end
                // A word completing while WR1 still holds the bus is lost.
                if (word_ready && (state_q != WR1)) begin
                    wr_q <= word_d;
                end
`ifdef CAM_SRAM_TEST_PATTERN_EN
                if (word_ready) begin
                    pattern_q <= pattern_q + 1'b1;
                end
`endif
                if (capturing && href_fall && !row_full) begin
                    row_q <= row_q + 1'b1;
                end
                case (state_q)
                    IDLE: state_q <= IDLE;
                    WAIT_WORD: begin
                        if (row_full) begin
                            state_q <= JPEG_START;
                            start_q <= 1'b1;
                        end else if (word_ready) begin
                            state_q <= WR1;
                            we_n_q  <= 1'b0;
                        end
                    end
                    WR1: begin
                        state_q <= WR2;
                        if (word_ready) begin
                            overflow_q <= 1'b1;
                        end
                    end
                    WR2: begin
                        addr_q <= addr_q + 1'b1;
                        if (word_ready) begin
                            state_q <= WR1;
                        end else begin
                            state_q <= WAIT_WORD;
                            we_n_q  <= 1'b1;
                        end
                    end
                    JPEG_START: begin
                        state_q   <= JPEG_BUSY;
                        working_q <= 1'b1;
                    end
                    JPEG_BUSY: begin
                        if (jpeg_done) begin
                            state_q   <= IDLE;
                            working_q <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign data_sram            = we_n_q ? {DW{1'bz}} : wr_q;
    assign write_en_n           = we_n_q;
    assign address_to_sram      = working_q ? address_from_dwt : addr_q;
    assign data_to_jpeg         = working_q ? data_sram : '0;
    assign jpeg_start_from_sram = start_q;
    assign jpeg_working         = working_q;
    assign overflow             = overflow_q;
    assign chip_en              = 1'b0;
    assign output_en            = 1'b0;
    assign adv                  = 1'b0;
    assign byte_en              = '0;

endmodule
